// File: rtl/sequence_player_if.sv
// Round-display bus between the sequence player and its controller/comparator.
// seq_dat carries the packed directions (the word "sequence" is reserved in SystemVerilog).
interface sequence_player_if;
  logic       start;
  logic       replay;
  logic [7:0] seq_dat;
  logic [1:0] led_dir;
  logic       led_on;
  logic       busy;
  logic       ready;
  logic       play_done;

  modport master (
    output start, replay,
    input  seq_dat, led_dir, led_on, busy, ready, play_done
  );

  modport slave (
    input  start, replay,
    output seq_dat, led_dir, led_on, busy, ready, play_done
  );
endinterface

// File: rtl/sequence_player.sv
// Simon Says sequence player: latches an LFSR byte and shows its four directions on the LEDs.
// Optional REPLAY_EN macro: replay in DONE re-plays the held sequence without drawing a new one.
module sequence_player #(
  parameter int         DWELL_CYCLES = 25000000,
  parameter int         GAP_CYCLES   = 12500000,
  parameter logic [7:0] SEED         = 8'hB8
) (
  input  logic              clock,
  input  logic              reset,
  sequence_player_if.slave  p
);

  localparam logic [7:0] SEED_NZ = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    seq_q, seq_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    led_dir_q, led_dir_d;
  logic          play_done_q, play_done_d;
  logic [1:0]    cur_dir;

  // Step idx occupies bits {~idx,1} downto {~idx,0}: idx 0 -> [7:6], idx 3 -> [1:0].
  assign cur_dir = seq_q[{~idx_q, 1'b1} -: 2];

  always_comb begin
    state_d     = state_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    seq_d       = seq_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    play_done_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (p.start) begin
          seq_d   = lfsr_q;
          idx_d   = 2'd0;
          cnt_d   = '0;
          state_d = SHOW;
        end
`ifdef REPLAY_EN
        else if (state_q == DONE && p.replay) begin
          idx_d   = 2'd0;
          cnt_d   = '0;
          state_d = SHOW;
        end
`endif
      end
      SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d     = DONE;
            play_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = SHOW;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    led_dir_d = (state_q == SHOW) ? cur_dir : led_dir_q;
  end

`ifndef REPLAY_EN
  logic unused_replay;
  assign unused_replay = p.replay;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_NZ;
      seq_q       <= 8'h00;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      led_dir_q   <= 2'd0;
      play_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      seq_q       <= seq_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      led_dir_q   <= led_dir_d;
      play_done_q <= play_done_d;
    end
  end

  assign p.seq_dat   = seq_q;
  assign p.led_dir   = led_dir_d;
  assign p.led_on    = (state_q == SHOW);
  assign p.busy      = (state_q == SHOW) || (state_q == GAP);
  assign p.ready     = (state_q == DONE);
  assign p.play_done = play_done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with DWELL_CYCLES=4, GAP_CYCLES=2, SEED=8'hB8.
module tb_sequence_player;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [7:0] model_lfsr;
  logic [7:0] exp_seq;
  bit   seen [256];
  int   zero_hits;
  int   dup_hits;

  sequence_player_if bus ();

  sequence_player #(
    .DWELL_CYCLES (4),
    .GAP_CYCLES   (2),
    .SEED         (8'hB8)
  ) dut (
    .clock (clk),
    .reset (rst),
    .p     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: value presented at the next edge is what a start would latch.
  always @(posedge clk)
    model_lfsr <= rst ? 8'hB8
                      : {model_lfsr[6:0], model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seq"},   bus.seq_dat, 8'h00);
    chk({tag, "_outs"},  {2'b0, bus.led_dir, bus.led_on, bus.busy, bus.ready, bus.play_done}, 8'h00);
  endtask

  // Entered at #1 after the start edge (t=0); leaves at t=25 in DONE.
  task automatic play_check(input string tag, input logic [7:0] seq_exp,
                            input logic [1:0] d0, input logic [1:0] d1,
                            input logic [1:0] d2, input logic [1:0] d3, input bit poke);
    logic [1:0] dirs [4];
    logic [7:0] exp_v;
    int pulses;
    dirs[0] = d0; dirs[1] = d1; dirs[2] = d2; dirs[3] = d3;
    pulses = 0;
    for (int t = 0; t <= 25; t++) begin
      if (t < 24)
        exp_v = {3'b0, ((t % 6) < 4), dirs[t / 6], 1'b1, 1'b0, 1'b0};
      else
        exp_v = {3'b0, 1'b0, bus.led_dir, 1'b0, 1'b1, (t == 24)};
      if (t >= 24) exp_v[4:3] = bus.led_dir;
      chk($sformatf("%s_t%0d", tag, t),
          {3'b0, bus.led_on, bus.led_dir, bus.busy, bus.ready, bus.play_done}, exp_v);
      chk($sformatf("%s_seq_t%0d", tag, t), bus.seq_dat, seq_exp);
      if (bus.play_done === 1'b1) pulses++;
      if (poke) bus.start = (t < 22) ? ((t % 2) == 1) : 1'b0;
      if (t < 25) step();
    end
    chk({tag, "_pulses"}, 8'(pulses), 8'd1);
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.replay = 1'b0;
    step();
    step();
    chk_reset_vals("reset");

    // 1: start on the first edge after reset release.
    rst = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    play_check("r1", 8'hB8, 2'd2, 2'd3, 2'd2, 2'd0, 1'b0);

    // 2 + 3: one idle cycle first, then start pokes during playback.
    rst = 1'b1;
    step();
    chk_reset_vals("reset2");
    rst = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    play_check("r2", 8'h70, 2'd1, 2'd3, 2'd0, 2'd0, 1'b1);

    // 4: reset on cycle 10 of playback abandons the round.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    chk("mid_busy", {7'b0, bus.busy}, 8'h01);
    rst = 1'b1;
    step();
    chk_reset_vals("midrst");
    rst = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    play_check("r4", 8'hB8, 2'd2, 2'd3, 2'd2, 2'd0, 1'b0);

    // 5: start and replay together draw a new sequence.
    exp_seq = model_lfsr;
    bus.start  = 1'b1;
    bus.replay = 1'b1;
    step();
    bus.start  = 1'b0;
    bus.replay = 1'b0;
    play_check("r5", exp_seq, exp_seq[7:6], exp_seq[5:4], exp_seq[3:2], exp_seq[1:0], 1'b0);

    bus.replay = 1'b1;
    step();
    bus.replay = 1'b0;
`ifdef REPLAY_EN
    play_check("replay", exp_seq, exp_seq[7:6], exp_seq[5:4], exp_seq[3:2], exp_seq[1:0], 1'b0);
`else
    chk("replay_ign", {5'b0, bus.ready, bus.busy, bus.led_on}, 8'h04);
    chk("replay_seq", bus.seq_dat, exp_seq);
    repeat (3) step();
    chk("replay_hold", {5'b0, bus.ready, bus.busy, bus.led_on}, 8'h04);
`endif

    // 6: 255 rounds, start edges 26 cycles apart (26 is coprime to 255).
    zero_hits = 0;
    dup_hits  = 0;
    for (int k = 0; k < 255; k++) begin
      exp_seq = model_lfsr;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk($sformatf("round%0d_seq", k), bus.seq_dat, exp_seq);
      if (bus.seq_dat == 8'h00) zero_hits++;
      if (seen[bus.seq_dat]) dup_hits++;
      seen[bus.seq_dat] = 1'b1;
      repeat (25) step();
    end
    chk("rounds_zero", 8'(zero_hits), 8'd0);
    chk("rounds_dup",  8'(dup_hits),  8'd0);
    chk("rounds_ready", {7'b0, bus.ready}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
